// File: rtl/mem_swap_engine_if.sv
// rtl/mem_swap_engine_if.sv - memory port bundle between swap engine and word memory
interface mem_swap_engine_if #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [WORD_SIZE-1:0]  reg_in;
    logic [WORD_SIZE-1:0]  reg_out;
    logic                  reg_READ_EN;
    logic                  reg_WRITE_EN;

    // Engine side drives address, write data and strobes.
    modport master (
        output reg_addr,
        output reg_in,
        output reg_READ_EN,
        output reg_WRITE_EN,
        input  reg_out
    );

    // Memory side returns read data one cycle after a read strobe.
    modport slave (
        input  reg_addr,
        input  reg_in,
        input  reg_READ_EN,
        input  reg_WRITE_EN,
        output reg_out
    );
endinterface

// File: rtl/mem_swap_engine.sv
// rtl/mem_swap_engine.sv - read two words, compare, conditionally swap them in memory
module mem_swap_engine #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int SIGNED_CMP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    mem_swap_engine_if.master     mem,
    output logic                  busy,
    output logic                  done,
    output logic                  swapped,
    output logic                  gt
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD1  = 3'd1;
    localparam logic [2:0] RD2  = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] WR1  = 3'd4;
    localparam logic [2:0] WR2  = 3'd5;
    localparam logic [2:0] DONE = 3'd6;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] a1_q;
    logic [ADDR_WIDTH-1:0] a2_q;
    logic [1:0]            mode_q;
    logic [WORD_SIZE-1:0]  temp1;
    logic                  cmp_gt;
    logic                  cmp_lt;
    logic                  do_swap;

    // Compare the first operand against the second word as it arrives on reg_out in CAP.
    always_comb begin
        cmp_gt  = 1'b0;
        cmp_lt  = 1'b0;
        do_swap = 1'b0;
        if (SIGNED_CMP != 0) begin
            cmp_gt = $signed(temp1) > $signed(mem.reg_out);
            cmp_lt = $signed(temp1) < $signed(mem.reg_out);
        end else begin
            cmp_gt = temp1 > mem.reg_out;
            cmp_lt = temp1 < mem.reg_out;
        end
        case (mode_q)
            2'b00:   do_swap = 1'b1;
            2'b01:   do_swap = cmp_gt;
            2'b10:   do_swap = cmp_lt;
            default: do_swap = 1'b0;
        endcase
    end

    // Sequencer: every output is registered with the values belonging to the state being entered.
    // The second operand is held directly in reg_in, which is exactly what WR1 must write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            a1_q             <= '0;
            a2_q             <= '0;
            mode_q           <= 2'b00;
            temp1            <= '0;
            mem.reg_addr     <= '0;
            mem.reg_in       <= '0;
            mem.reg_READ_EN  <= 1'b0;
            mem.reg_WRITE_EN <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            swapped          <= 1'b0;
            gt               <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a1_q    <= addr1;
                        a2_q    <= addr2;
                        mode_q  <= mode;
                        swapped <= 1'b0;
                        gt      <= 1'b0;
                        busy    <= 1'b1;
                        if (addr1 == addr2) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state           <= RD1;
                            mem.reg_addr    <= addr1;
                            mem.reg_READ_EN <= 1'b1;
                        end
                    end
                end
                RD1: begin
                    state           <= RD2;
                    mem.reg_addr    <= a2_q;
                    mem.reg_READ_EN <= 1'b1;
                end
                RD2: begin
                    temp1           <= mem.reg_out;
                    state           <= CAP;
                    mem.reg_READ_EN <= 1'b0;
                end
                CAP: begin
                    gt <= cmp_gt;
                    if (do_swap) begin
                        state            <= WR1;
                        mem.reg_addr     <= a1_q;
                        mem.reg_in       <= mem.reg_out;
                        mem.reg_WRITE_EN <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                WR1: begin
                    state            <= WR2;
                    mem.reg_addr     <= a2_q;
                    mem.reg_in       <= temp1;
                    mem.reg_WRITE_EN <= 1'b1;
                    swapped          <= 1'b1;
                end
                WR2: begin
                    state            <= DONE;
                    mem.reg_WRITE_EN <= 1'b0;
                    done             <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state            <= IDLE;
                    mem.reg_READ_EN  <= 1'b0;
                    mem.reg_WRITE_EN <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_swap_engine.sv
// tb/tb_mem_swap_engine.sv - randomized bench for mem_swap_engine, unsigned and signed instances
module tb_mem_swap_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [1:0]  busy_v, done_v, swapped_v, gt_v;

    mem_swap_engine_if #(.WORD_SIZE(16), .ADDR_WIDTH(16)) bus_u ();
    mem_swap_engine_if #(.WORD_SIZE(16), .ADDR_WIDTH(16)) bus_s ();

    mem_swap_engine #(.WORD_SIZE(16), .ADDR_WIDTH(16), .SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .addr1(addr1), .addr2(addr2),
        .mem(bus_u.master), .busy(busy_v[0]), .done(done_v[0]), .swapped(swapped_v[0]), .gt(gt_v[0])
    );

    mem_swap_engine #(.WORD_SIZE(16), .ADDR_WIDTH(16), .SIGNED_CMP(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .addr1(addr1), .addr2(addr2),
        .mem(bus_s.master), .busy(busy_v[1]), .done(done_v[1]), .swapped(swapped_v[1]), .gt(gt_v[1])
    );

    logic [1:0]  re_v, we_v;
    logic [15:0] addr_v [2];
    logic [15:0] in_v [2];
    logic [15:0] rd_q [2];
    logic [15:0] mem_q [2][16];
    logic [15:0] ref_mem [2][16];
    logic        poke_en;
    logic [3:0]  poke_addr;
    logic [15:0] poke_data;

    assign re_v      = {bus_s.reg_READ_EN, bus_u.reg_READ_EN};
    assign we_v      = {bus_s.reg_WRITE_EN, bus_u.reg_WRITE_EN};
    assign addr_v[0] = bus_u.reg_addr;
    assign addr_v[1] = bus_s.reg_addr;
    assign in_v[0]   = bus_u.reg_in;
    assign in_v[1]   = bus_s.reg_in;
    assign bus_u.reg_out = rd_q[0];
    assign bus_s.reg_out = rd_q[1];

    // Word memories with one-cycle read latency, plus a preload port for the bench.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (poke_en) mem_q[i][poke_addr] <= poke_data;
            else if (we_v[i]) mem_q[i][addr_v[i][3:0]] <= in_v[i];
            if (re_v[i]) rd_q[i] <= mem_q[i][addr_v[i][3:0]];
        end
    end

    int passed = 0;
    int total  = 0;
    int op_num = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic string nm(input string base, input int i);
        return $sformatf("op%0d_%s_%s", op_num, base, (i == 1) ? "signed" : "unsigned");
    endfunction

    function automatic bit mem_matches(input int i);
        bit ok = 1'b1;
        for (int a = 0; a < 16; a++) if (mem_q[i][a] !== ref_mem[i][a]) ok = 1'b0;
        return ok;
    endfunction

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++)
            chk(nm(tag, i), {busy_v[i], done_v[i], swapped_v[i], gt_v[i], re_v[i], we_v[i], addr_v[i], in_v[i]}, 64'd0);
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        poke_en   = 1'b1;
        poke_addr = a[3:0];
        poke_data = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        ref_mem[0][a] = d;
        ref_mem[1][a] = d;
    endtask

    // Reference: operate on integer values; the signed view maps the top half of the range to negatives.
    task automatic model(input int i, input int a1, input int a2, input logic [1:0] m,
                         output int lat, output int wr, output int rd, output logic sw, output logic g);
        int  x1, x2;
        bit  do_sw;
        logic [15:0] v1, v2;
        if (a1 == a2) begin
            lat = 1; wr = 0; rd = 0; sw = 1'b0; g = 1'b0;
        end else begin
            v1 = ref_mem[i][a1];
            v2 = ref_mem[i][a2];
            x1 = int'(v1);
            x2 = int'(v2);
            if (i == 1 && x1 >= 32768) x1 = x1 - 65536;
            if (i == 1 && x2 >= 32768) x2 = x2 - 65536;
            g     = (x1 > x2);
            do_sw = (m == 2'd0) || (m == 2'd1 && x1 > x2) || (m == 2'd2 && x1 < x2);
            sw    = do_sw;
            lat   = do_sw ? 6 : 4;
            wr    = do_sw ? 2 : 0;
            rd    = 2;
            if (do_sw) begin
                ref_mem[i][a1] = v2;
                ref_mem[i][a2] = v1;
            end
        end
    endtask

    task automatic run_op(input int a1, input int a2, input logic [1:0] m);
        int   lat_e [2], wr_e [2], rd_e [2];
        logic sw_e [2], gt_e [2];
        int   lat_a [2], wr_a [2], rd_a [2], dn_a [2];
        int   overlap;
        op_num++;
        overlap = 0;
        for (int i = 0; i < 2; i++) begin
            model(i, a1, a2, m, lat_e[i], wr_e[i], rd_e[i], sw_e[i], gt_e[i]);
            lat_a[i] = 0; wr_a[i] = 0; rd_a[i] = 0; dn_a[i] = 0;
        end
        addr1 = a1[15:0];
        addr2 = a2[15:0];
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (done_v[i]) begin
                    dn_a[i]++;
                    if (lat_a[i] == 0) lat_a[i] = k;
                end
                if (we_v[i]) wr_a[i]++;
                if (re_v[i]) rd_a[i]++;
                if (we_v[i] && re_v[i]) overlap++;
            end
            if (lat_a[0] != 0 && lat_a[1] != 0) break;
            addr1 = 16'($urandom);
            addr2 = 16'($urandom);
            mode  = 2'($urandom);
            start = (k == 2 && a1 != a2);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (done_v[i]) dn_a[i]++;
            chk(nm("latency", i), 64'(lat_a[i]), 64'(lat_e[i]));
            chk(nm("swapped", i), 64'(swapped_v[i]), 64'(sw_e[i]));
            chk(nm("gt", i), 64'(gt_v[i]), 64'(gt_e[i]));
            chk(nm("writes", i), 64'(wr_a[i]), 64'(wr_e[i]));
            chk(nm("reads", i), 64'(rd_a[i]), 64'(rd_e[i]));
            chk(nm("done_width", i), 64'(dn_a[i]), 64'd1);
            chk(nm("busy_after", i), 64'(busy_v[i]), 64'd0);
            chk(nm("memory", i), 64'(mem_matches(i)), 64'd1);
        end
        chk($sformatf("op%0d_rw_overlap", op_num), 64'(overlap), 64'd0);
    endtask

    task automatic reset_during_wr1();
        int wr_a [2], dn_a [2];
        op_num++;
        addr1 = 16'd2;
        addr2 = 16'd11;
        mode  = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("op%0d_in_wr1", op_num), 64'(we_v), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("abort");
        for (int i = 0; i < 2; i++) begin
            ref_mem[i][2] = ref_mem[i][11];
            wr_a[i] = 0;
            dn_a[i] = 0;
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (we_v[i]) wr_a[i]++;
                if (done_v[i]) dn_a[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk(nm("abort_writes", i), 64'(wr_a[i]), 64'd0);
            chk(nm("abort_done", i), 64'(dn_a[i]), 64'd0);
            chk(nm("abort_memory", i), 64'(mem_matches(i)), 64'd1);
        end
    endtask

    initial begin
        int a1, a2;
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        addr1     = 16'd0;
        addr2     = 16'd0;
        poke_en   = 1'b0;
        poke_addr = 4'd0;
        poke_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        start = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("reset_over_start");
        start = 1'b0;
        rst   = 1'b0;

        for (int a = 0; a < 16; a++) poke(a, 16'($urandom));

        poke(3, 16'd7); poke(9, 16'd2);
        run_op(3, 9, 2'b00);
        poke(3, 16'd2); poke(9, 16'd7);
        run_op(3, 9, 2'b01);
        poke(0, 16'hFFFF); poke(1, 16'd1);
        run_op(0, 1, 2'b10);
        run_op(5, 5, 2'b00);
        poke(4, 16'h8001); poke(6, 16'h8001);
        run_op(4, 6, 2'b01);
        run_op(4, 6, 2'b10);
        run_op(4, 6, 2'b11);

        for (int n = 0; n < 40; n++) begin
            a1 = int'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 7) == 0) ? a1 : int'($urandom_range(0, 15));
            run_op(a1, a2, 2'($urandom_range(0, 3)));
        end

        reset_during_wr1();
        run_op(7, 12, 2'b00);
        run_op(12, 7, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_swap_engine.md
MEM_SWAP_ENGINE -- requirements
Module: mem_swap_engine

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning the memory data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, meaning the memory address width in bits.
REQ-003 The block SHALL have parameter SIGNED_CMP, default 0, meaning compare as two's-complement when 1 and unsigned when 0.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request, sampled only in IDLE.
REQ-008 mode  input  2  operation: 00 unconditional swap, 01 swap if M[a1]>M[a2], 10 swap if M[a1]<M[a2], 11 compare only.
REQ-009 addr1, addr2  input  ADDR_WIDTH each  operand addresses, latched on accepted start.
REQ-010 reg_out  input  WORD_SIZE  memory read data, valid the cycle after the address is presented with reg_READ_EN=1.
REQ-011 reg_addr  output  ADDR_WIDTH  memory address.
REQ-012 reg_in  output  WORD_SIZE  memory write data.
REQ-013 reg_READ_EN, reg_WRITE_EN  output  1 each  memory read and write strobes.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 swapped  output  1  1 if writes were performed by the last operation; held until the next accepted start.
REQ-017 gt  output  1  1 if M[a1]>M[a2] under SIGNED_CMP; held until the next accepted start.

Function
REQ-018 All outputs SHALL be registered; states SHALL be IDLE, RD1, RD2, CAP, WR1, WR2, DONE.
REQ-019 IDLE, start=1: latch addr1, addr2, mode; clear swapped and gt; go DONE if addr1==addr2, else RD1; start=0: stay.
REQ-020 RD1: reg_addr=a1, reg_READ_EN=1, reg_WRITE_EN=0; go RD2.
REQ-021 RD2: reg_addr=a2, reg_READ_EN=1; capture reg_out into temp1; go CAP.
REQ-022 CAP: reg_READ_EN=0; capture reg_out into temp2; set gt = temp1>reg_out; decision: 00 always swap, 01 swap if gt, 10 swap if temp1<reg_out, 11 never; swap: go WR1, else go DONE.
REQ-023 WR1: reg_addr=a1, reg_in=temp2, reg_WRITE_EN=1; go WR2.
REQ-024 WR2: reg_addr=a2, reg_in=temp1, reg_WRITE_EN=1; set swapped=1; go DONE.
REQ-025 DONE: reg_WRITE_EN=0, reg_READ_EN=0, done=1 for exactly one cycle; go IDLE.
REQ-026 Latency from the start-sampling edge to done high: 6 cycles with swap, 4 cycles without swap, 1 cycle for addr1==addr2.
REQ-027 The addr1==addr2 case SHALL perform no memory access and report swapped=0, gt=0.
REQ-028 Equal data values SHALL not swap in modes 01 and 10.
REQ-029 start while busy=1 SHALL be ignored and SHALL not alter latched operands.
REQ-030 Changes on addr1, addr2 or mode after acceptance SHALL not affect the operation in progress.
REQ-031 reg_READ_EN and reg_WRITE_EN SHALL never be high in the same cycle.
REQ-032 Exactly two write cycles SHALL occur per swap and zero otherwise.
REQ-033 Back-to-back operation: start in the cycle after done SHALL be accepted.

Reset
REQ-034 With rst=1 at a clock edge, the block SHALL enter IDLE and drive reg_addr=0, reg_in=0, reg_READ_EN=0, reg_WRITE_EN=0, busy=0, done=0, swapped=0, gt=0.
REQ-035 rst SHALL take priority over start and abort any operation in progress; no further writes and no done pulse SHALL follow.

Verification
REQ-036 M[3]=7, M[9]=2, mode=00, start -> WR1 writes 2 to addr 3, WR2 writes 7 to addr 9, done 6 cycles after start, swapped=1, gt=1.
REQ-037 M[3]=2, M[9]=7, mode=01 -> no write strobe, done after 4 cycles, swapped=0, gt=0; memory unchanged.
REQ-038 SIGNED_CMP=1, WORD_SIZE=16, M[0]=16'hFFFF, M[1]=1, mode=10 -> swap occurs (-1<1), M[0]=1, M[1]=16'hFFFF; with SIGNED_CMP=0 -> no swap.
REQ-039 addr1=addr2=5, mode=00 -> done 1 cycle after start, no read or write strobe, swapped=0.
REQ-040 rst asserted during WR1 -> next cycle all outputs 0, state IDLE, no WR2 write, no done pulse.
REQ-041 start pulsed during RD2 with different addresses -> ignored; the original operation completes unchanged.
